fifo_sync_param: RTL and testbench

// - Parametrised single-clock FIFO for transaction-layer buffering (VC/TLP queues).
// - Built on a generalised dual-port RAM with registered read data.
// - Adds occupancy count, almost-full/almost-empty thresholds for upstream pause, and sticky overflow/underflow errors.

---
 rtl/fifo_sync_param_pkg.sv | 11 +
 rtl/fifo_mem_dp.sv | 40 ++++
 rtl/fifo_sync_param.sv | 125 ++++++++++++
 tb/tb_fifo_sync_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Constants shared by the FIFO, its RAM and the transaction-layer modules.
package fifo_sync_param_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 12;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 3;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Single-clock dual-port RAM: one write port and one registered read port.
module fifo_mem_dp
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned LINE_SIZE    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_SIZE = DEFAULT_ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_en,
    input  logic [ADDRESS_SIZE-1:0] i_wr_addr,
    input  logic [LINE_SIZE-1:0]    i_wr_data,
    input  logic                    i_rd_en,
    input  logic [ADDRESS_SIZE-1:0] i_rd_addr,
    output logic [LINE_SIZE-1:0]    o_rd_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDRESS_SIZE);

    logic [LINE_SIZE-1:0] r_mem [DEPTH];
    logic [LINE_SIZE-1:0] r_rd_data;

    // Storage array has no reset; only the read register is cleared.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow error flags.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_e,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_e,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
        $error("fifo_sync_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CNT_W-1:0] w_count_d;
    logic             w_overflow_d;
    logic             w_underflow_d;

    // Flags depend on the registered count only, never on the requests.
    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign fifo_count   = r_count;
    assign valid_out    = r_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_e && !full;
    assign w_rd_acc = rd_e && !empty;

    always_comb begin
        w_count_d = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_d = r_count + 1'b1;
            2'b01:   w_count_d = r_count - 1'b1;
            default: w_count_d = r_count;
        endcase
    end

    // A new error on the same edge as err_clr keeps the flag set.
    always_comb begin
        w_overflow_d  = r_overflow;
        w_underflow_d = r_underflow;
        if (err_clr) begin
            w_overflow_d  = 1'b0;
            w_underflow_d = 1'b0;
        end
        if (wr_e && full) begin
            w_overflow_d = 1'b1;
        end
        if (rd_e && empty) begin
            w_underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_d;
            r_valid     <= w_rd_acc;
            r_overflow  <= w_overflow_d;
            r_underflow <= w_underflow_d;
        end
    end

    fifo_mem_dp #(
        .LINE_SIZE    (DATA_WIDTH),
        .ADDRESS_SIZE (ADDR_WIDTH)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (reset_L),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: queue-based reference model plus a
// monitor that checks every output one tick after each rising edge.
module tb_fifo_sync_param;

    localparam int DW    = 12;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          wr_e;
    logic [DW-1:0] data_in;
    logic          rd_e;
    logic          err_clr;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic          underflow;

    fifo_sync_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_e         (wr_e),
        .data_in      (data_in),
        .rd_e         (rd_e),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model state (post-edge view).
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] sb[$];
    logic          m_valid;
    logic          m_ov;
    logic          m_un;
    logic [DW-1:0] last_data;
    bit            chk_en;

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request set and advance the model to the state after the next edge.
    task automatic step(input bit wr, input logic [DW-1:0] din, input bit rd, input bit clr);
        bit acc_w;
        bit acc_r;
        wr_e    = wr;
        data_in = din;
        rd_e    = rd;
        err_clr = clr;
        acc_w = wr && (m_q.size() < DEPTH);
        acc_r = rd && (m_q.size() > 0);
        if (acc_r) sb.push_back(m_q.pop_front());
        if (acc_w) m_q.push_back(din);
        m_valid = acc_r;
        m_ov = (wr && !acc_w) ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_un = (rd && !acc_r) ? 1'b1 : (clr ? 1'b0 : m_un);
    endtask

    task automatic cycle(input bit wr, input logic [DW-1:0] din, input bit rd, input bit clr);
        step(wr, din, rd, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_valid   = 1'b0;
        m_ov      = 1'b0;
        m_un      = 1'b0;
        last_data = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(valid_out), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_afull"}, 32'(almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        chk({tag, "_unf"}, 32'(underflow), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("valid_out", 32'(valid_out), 32'(m_valid));
            if (valid_out) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun", 32'd1, 32'd0);
                end else begin
                    last_data = sb.pop_front();
                    chk("data_out", 32'(data_out), 32'(last_data));
                end
            end else begin
                chk("data_hold", 32'(data_out), 32'(last_data));
            end
            chk("count", 32'(fifo_count), 32'(m_q.size()));
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= AE));
            chk("overflow", 32'(overflow), 32'(m_ov));
            chk("underflow", 32'(underflow), 32'(m_un));
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        reset_L  = 1'b0;
        wr_e     = 1'b0;
        rd_e     = 1'b0;
        err_clr  = 1'b0;
        data_in  = '0;
        model_reset();
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_L = 1'b1;
        chk_en  = 1'b1;

        // Fill 0x001..0x008, then one rejected write.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        cycle(1'b1, 12'hFFF, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Simultaneous read+write on empty: write wins, no bypass.
        cycle(1'b1, 12'hABC, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Steady state at count 4 with pointer wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
        while (m_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Full with read+write, then clear; then clear colliding with new error.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 12'h5A5, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 12'h111, 1'b0, 1'b0);
        cycle(1'b1, 12'h222, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        while (m_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'(($urandom % 100) < 55), DW'($urandom), 1'(($urandom % 100) < 50),
                  1'(($urandom % 100) < 5));
        end
        while (m_q.size() > 0) cycle(1'b0, '0, 1'b1, 1'b0);

        // Reset mid-burst with a read in flight and sticky underflow set.
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        chk("pre_reset_valid", 32'(valid_out), 32'd1);
        chk_en  = 1'b0;
        reset_L = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        wr_e = 1'b0;
        rd_e = 1'b0;
        err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        chk_en  = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
